// File: rtl/dxi_filter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dxi_pkg
//  Purpose  : Shared widths, filter-select encoding, issue-FSM states and the
//             3x3 kernel table used by the filter arbiter and its reference
//             model.
//  Revision : 1.0 - initial release
// ============================================================================
package dxi_pkg;

    localparam int DXI_WIN_W = 72;   // nine 8-bit pixels, pixel i at [i*8 +: 8]
    localparam int DXI_PIX_W = 8;
    localparam int DXI_CFG_W = 2;

    typedef enum logic [1:0] {
        CFG_LAP1  = 2'd0,
        CFG_LAP2  = 2'd1,
        CFG_GAUSS = 2'd2,
        CFG_AVG   = 2'd3
    } dxi_cfg_e;

    // Issue register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } dxi_issue_st_e;

    // Kernel coefficients indexed by filter select, then pixel position
    localparam int c_kernel_coef [4][9] = '{
        '{ 0, -1,  0, -1,  4, -1,  0, -1,  0},
        '{-1, -1, -1, -1,  8, -1, -1, -1, -1},
        '{ 1,  2,  1,  2,  4,  2,  1,  2,  1},
        '{ 1,  1,  1,  1,  1,  1,  1,  1,  1}
    };

    // Divisor applied to the weighted sum before clamping to 0..255
    localparam int c_kernel_norm [4] = '{1, 1, 16, 9};

endpackage
`default_nettype wire

// File: rtl/dxi_filter_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dxi_filter_arbiter_if
//  Purpose  : Requester, response and filter-side handshake bundle of the
//             filter arbiter. slave = arbiter view, master = surroundings.
//  Revision : 1.0 - initial release
// ============================================================================
interface dxi_filter_arbiter_if #(
    parameter int N_REQ = 4
);
    import dxi_pkg::*;

    // requester side
    logic [N_REQ-1:0]           i_req_valid;
    logic [N_REQ*DXI_WIN_W-1:0] i_req_data;
    logic [N_REQ*DXI_CFG_W-1:0] i_req_cfg;
    logic [N_REQ-1:0]           o_req_ready;
    logic [N_REQ-1:0]           o_rsp_valid;
    logic [DXI_PIX_W-1:0]       o_rsp_data;
    logic [N_REQ-1:0]           i_rsp_ready;

    // filter side
    logic                       o_flt_valid;
    logic [DXI_WIN_W-1:0]       o_flt_data;
    logic [DXI_CFG_W-1:0]       o_flt_cfg;
    logic                       i_flt_ready;
    logic                       i_flt_out_valid;
    logic [DXI_PIX_W-1:0]       i_flt_out_data;
    logic                       o_flt_out_ready;

    modport slave (
        input  i_req_valid, i_req_data, i_req_cfg, i_rsp_ready,
               i_flt_ready, i_flt_out_valid, i_flt_out_data,
        output o_req_ready, o_rsp_valid, o_rsp_data,
               o_flt_valid, o_flt_data, o_flt_cfg, o_flt_out_ready
    );

    modport master (
        output i_req_valid, i_req_data, i_req_cfg, i_rsp_ready,
               i_flt_ready, i_flt_out_valid, i_flt_out_data,
        input  o_req_ready, o_rsp_valid, o_rsp_data,
               o_flt_valid, o_flt_data, o_flt_cfg, o_flt_out_ready
    );

endinterface
`default_nettype wire

// File: rtl/dxi_filter_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dxi_tag_fifo
//  Purpose  : In-order tag FIFO recording which requester owns each window
//             handed to the filter. Push and pop may coincide even when full
//             or empty; a pop of an empty FIFO is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module dxi_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8     // power of 2, at least 2
) (
    input  wire logic                     i_clk,
    input  wire logic                     i_rstn,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_pop_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    // A pop frees the head slot, so a full FIFO can accept a push in that cycle
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    // Pointer and storage update
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dxi_filter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dxi_filter_arbiter
//  Purpose  : Shares one 3x3 filter between N_REQ window requesters. Windows
//             are granted round-robin into a single issue register, the owner
//             ID is queued in order, and each filter result is steered back
//             to the requester that issued it.
//  Revision : 1.0 - initial release
// ============================================================================
module dxi_filter_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  wire logic                        i_clk,
    input  wire logic                        i_rstn,
    dxi_filter_arbiter_if.slave              bus,
    output logic [$clog2(TAG_DEPTH):0]       o_inflight,
    output logic                             o_err_orphan
);
    import dxi_pkg::*;

    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = $clog2(TAG_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(TAG_DEPTH);

    dxi_issue_st_e          r_state;
    dxi_issue_st_e          w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_id;
    logic [DXI_WIN_W-1:0]   r_data;
    logic [DXI_CFG_W-1:0]   r_cfg;
    logic                   r_err_orphan;

    logic [ID_W-1:0]        w_id_inc;
    logic [ID_W-1:0]        w_ptr;
    logic [ID_W-1:0]        w_grant_id;
    logic                   w_grant_found;
    logic                   w_load;
    logic                   w_push;
    logic                   w_pop;
    logic [N_REQ-1:0]       w_req_ready;
    logic [N_REQ-1:0]       w_rsp_valid;
    logic [c_cnt_w-1:0]     w_tags_avail;
    logic [c_cnt_w-1:0]     w_fifo_count;
    logic [ID_W-1:0]        w_head;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_unused;

    // Outstanding windows: queued tags plus the one waiting in the issue register
    assign o_inflight   = w_fifo_count + c_cnt_w'(r_state == ST_FULL);
    assign w_tags_avail = c_depth - o_inflight;
    assign o_err_orphan = r_err_orphan;

    // Next requester after the one currently held, wrapping at N_REQ
    assign w_id_inc = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
    // While FULL the pointer effectively advances in the same cycle as the push
    assign w_ptr    = (r_state == ST_FULL) ? w_id_inc : r_rr_ptr;

    // Round-robin search: first valid requester at or after w_ptr
    always_comb begin : p_grant
        int v_idx;
        v_idx         = 0;
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            v_idx = int'(w_ptr) + i;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (bus.i_req_valid[v_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(v_idx);
            end
        end
    end

    // Issue FSM: decide load/push and the single requester accept pulse
    always_comb begin : p_issue_fsm
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_push      = 1'b0;
        w_req_ready = '0;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant_found && (w_tags_avail != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.i_flt_ready) begin
                    w_push = 1'b1;
                    if (w_grant_found && (w_tags_avail > c_cnt_w'(1))) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (w_load) begin
            w_req_ready[w_grant_id] = 1'b1;
        end
    end

    // Issue register, round-robin pointer and sticky orphan flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= ST_EMPTY;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_data       <= '0;
            r_cfg        <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= bus.i_req_data[int'(w_grant_id)*DXI_WIN_W +: DXI_WIN_W];
                r_cfg  <= bus.i_req_cfg[int'(w_grant_id)*DXI_CFG_W +: DXI_CFG_W];
                r_id   <= w_grant_id;
            end
            if (w_push) begin
                r_rr_ptr <= w_id_inc;
            end
            if (bus.i_flt_out_valid && w_fifo_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign bus.o_req_ready = w_req_ready;
    assign bus.o_flt_valid = (r_state == ST_FULL);
    assign bus.o_flt_data  = r_data;
    assign bus.o_flt_cfg   = r_cfg;

    dxi_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (w_push),
        .i_push_data (r_id),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Occupancy never exceeds TAG_DEPTH by construction, so full is informational
    assign w_unused = w_fifo_full;

    // Return path: steer the result to the head owner; drain orphans
    always_comb begin : p_return
        w_rsp_valid = '0;
        if (bus.i_flt_out_valid && !w_fifo_empty) begin
            w_rsp_valid[w_head] = 1'b1;
        end
    end

    assign bus.o_rsp_valid     = w_rsp_valid;
    assign bus.o_rsp_data      = bus.i_flt_out_data;
    assign bus.o_flt_out_ready = w_fifo_empty ? 1'b1 : bus.i_rsp_ready[w_head];
    assign w_pop               = bus.i_flt_out_valid && bus.o_flt_out_ready && !w_fifo_empty;

endmodule
`default_nettype wire
